// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: latches operands on launch, holds busy for a programmable
// count, then commits the product or quotient/remainder to HI/LO. Also handles MTHI/MTLO and the D-stage stall.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       mduop_i,
  input  logic [CNT_W-1:0] time_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic [1:0]       read_hilo_i,
  input  logic             md_type_d_i,
  output logic [WIDTH-1:0] hilo_out_o,
  output logic             busy_o,
  output logic             stall_md_o
);

  // state  | meaning
  // S_IDLE | no op in flight; accepts launch and MTHI/MTLO
  // S_BUSY | counting down; commits HI/LO when the count reaches 1
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic                launch;
  logic [2*WIDTH-1:0]  mul_s, mul_u;
  logic [WIDTH-1:0]    div_b;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]    quo_s, rem_s, quo_u, rem_u;

  assign launch = start_i && (mduop_i inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

  assign mul_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign mul_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // Divisor forced to 1 when zero so the dividers never see x; the commit is suppressed anyway.
  assign div_b = (b_q == '0) ? WIDTH'(1) : b_q;
  assign a_s   = $signed(a_q);
  assign b_s   = $signed(div_b);
  assign quo_s = a_s / b_s;
  assign rem_s = a_s % b_s;
  assign quo_u = a_q / div_b;
  assign rem_u = a_q % div_b;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          a_d     = rs_i;
          b_d     = rt_i;
          op_d    = mduop_i;
          cnt_d   = (time_i == '0) ? CNT_W'(1) : time_i;
          state_d = S_BUSY;
        end else if (!start_i && mduop_i == OP_MTHI) begin
          hi_d = rs_i;
        end else if (!start_i && mduop_i == OP_MTLO) begin
          lo_d = rs_i;
        end
      end
      S_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = mul_s;
            OP_MULTU: {hi_d, lo_d} = mul_u;
            OP_DIV: if (b_q != '0) begin
              lo_d = quo_s;
              hi_d = rem_s;
            end
            OP_DIVU: if (b_q != '0) begin
              lo_d = quo_u;
              hi_d = rem_u;
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q == S_BUSY);
  assign stall_md_o = md_type_d_i && (start_i || busy_o);

  always_comb begin
    case (read_hilo_i)
      2'b10:   hilo_out_o = hi_q;
      2'b01:   hilo_out_o = lo_q;
      default: hilo_out_o = '0;
    endcase
  end

endmodule
